// File: rtl/rst_ctrl.sv
// Reset controller: free-running ck_en prescaler, lock-gated reset stretcher and optional watchdog.
// Define RST_CTRL_WDOG_EN to compile in the watchdog; without it kick is ignored and wdog_expired is 0.
module rst_ctrl #(
  parameter int DIV        = 16,
  parameter int RST_CYCLES = 5,
  parameter int WDOG_BITS  = 14
) (
  input  logic       ck,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       reset_req,
  input  logic       kick,
  output logic       ck_en,
  output logic       sys_rst,
  output logic [1:0] rst_cause,
  output logic       wdog_expired
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = $clog2(RST_CYCLES + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [SW-1:0] STR_LAST = SW'(RST_CYCLES - 1);

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_REQ  = 2'b01;
  localparam logic [1:0] CAUSE_WDOG = 2'b10;
  localparam logic [1:0] CAUSE_LOCK = 2'b11;

  typedef enum logic [1:0] {HOLD, STRETCH, RUN} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic            ck_en_q, ck_en_d;
  logic [SW-1:0]   str_q, str_d;
  logic [1:0]      cause_q, cause_d;
  logic            sys_rst_q, sys_rst_d;
  logic            wd_expire;

  // Prescaler runs regardless of FSM state so ck_en timing never depends on reset activity.
  always_comb begin
    pre_d   = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    ck_en_d = (pre_q == PRE_LAST);
  end

  always_comb begin
    state_d = state_q;
    str_d   = str_q;
    cause_d = cause_q;
    if (!locked) begin
      state_d = HOLD;
      str_d   = '0;
      if (state_q != HOLD) cause_d = CAUSE_LOCK;
    end else begin
      case (state_q)
        HOLD: begin
          state_d = STRETCH;
          str_d   = '0;
        end
        STRETCH: begin
          if (reset_req) begin
            str_d   = '0;
            cause_d = CAUSE_REQ;
          end else if (ck_en_q) begin
            if (str_q == STR_LAST) begin
              state_d = RUN;
              str_d   = '0;
            end else begin
              str_d = str_q + 1'b1;
            end
          end
        end
        RUN: begin
          if (reset_req) begin
            state_d = STRETCH;
            str_d   = '0;
            cause_d = CAUSE_REQ;
          end else if (wd_expire) begin
            state_d = STRETCH;
            str_d   = '0;
            cause_d = CAUSE_WDOG;
          end
        end
        default: begin
          state_d = HOLD;
          str_d   = '0;
        end
      endcase
    end
    sys_rst_d = (state_d != RUN);
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HOLD;
      pre_q     <= '0;
      ck_en_q   <= 1'b0;
      str_q     <= '0;
      cause_q   <= CAUSE_POR;
      sys_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      ck_en_q   <= ck_en_d;
      str_q     <= str_d;
      cause_q   <= cause_d;
      sys_rst_q <= sys_rst_d;
    end
  end

`ifdef RST_CTRL_WDOG_EN
  logic [WDOG_BITS-1:0] wd_q, wd_d;
  logic                 wexp_q;

  // Higher-priority causes (lock loss, request) suppress expiry in the same cycle.
  assign wd_expire = (state_q == RUN) && locked && !reset_req && ck_en_q && !kick &&
                     (wd_q == '1);

  always_comb begin
    wd_d = wd_q;
    if (state_q != RUN || kick)        wd_d = '0;
    else if (ck_en_q && wd_q != '1)    wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      wd_q   <= '0;
      wexp_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      wexp_q <= wd_expire;
    end
  end

  assign wdog_expired = wexp_q;
`else
  logic unused_kick;
  assign unused_kick  = kick;
  assign wd_expire    = 1'b0;
  assign wdog_expired = 1'b0;
`endif

  assign ck_en     = ck_en_q;
  assign sys_rst   = sys_rst_q;
  assign rst_cause = cause_q;

endmodule

// File: doc/rst_ctrl.md
RST_CTRL -- requirements
Module: rst_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 16: clock-enable divide ratio, legal range 1..65536.
REQ-002 SHALL have parameter RST_CYCLES, default 5: reset stretch length in ck_en ticks, at least 1.
REQ-003 SHALL have parameter WDOG_BITS, default 14: watchdog counter width, at least 2.
REQ-004 SHALL have port ck, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port locked, input, 1 bit: PLL lock indication, already synchronous to ck.
REQ-007 SHALL have port reset_req, input, 1 bit: synchronous software/system reset request, sampled every ck.
REQ-008 SHALL have port kick, input, 1 bit: watchdog service strobe, sampled every ck.
REQ-009 SHALL have port ck_en, output, 1 bit: registered one-cycle enable pulse at ck/DIV.
REQ-010 SHALL have port sys_rst, output, 1 bit: registered active-high synchronous reset for downstream logic.
REQ-011 SHALL have port rst_cause, output, 2 bits: last reset cause; 00 power-on, 01 request, 10 watchdog, 11 lock loss.
REQ-012 SHALL have port wdog_expired, output, 1 bit: one-ck pulse on watchdog expiry.

Function
REQ-013 Prescaler SHALL free-run in every state: counter 0..DIV-1, wrapping to 0; ck_en is 1 in the cycle after the counter equals DIV-1.
REQ-014 With DIV=1, ck_en SHALL be 1 on every cycle after reset release.
REQ-015 FSM states: HOLD, STRETCH, RUN; sys_rst=1 in HOLD and STRETCH, 0 only in RUN.
REQ-016 HOLD->STRETCH when locked=1; stretch counter cleared on entry.
REQ-017 STRETCH: counter increments on each ck_en; on the RST_CYCLES-th tick -> RUN, sys_rst falls on the next ck edge.
REQ-018 Any state with locked=0 -> HOLD next cycle; from STRETCH or RUN this also sets rst_cause=11.
REQ-019 reset_req=1 in STRETCH or RUN -> STRETCH next cycle with stretch counter cleared and rst_cause=01; reset_req in HOLD is ignored.
REQ-020 Watchdog counter SHALL be cleared on RUN entry; in RUN it increments on ck_en and clears on kick.
REQ-021 Expiry: in RUN, counter at 2^WDOG_BITS-1, ck_en=1 and kick=0 -> STRETCH, rst_cause=10, wdog_expired=1 for one cycle.
REQ-022 kick coincident with the terminal tick SHALL clear the counter; no expiry.
REQ-023 Priority per cycle: locked=0 > reset_req > watchdog expiry.
REQ-024 Stretch counter width SHALL be clog2(RST_CYCLES+1); no counter overflows.
REQ-025 rst_cause SHALL hold its value until the next cause event and SHALL not change on STRETCH->RUN.

Reset
REQ-026 rst_n=0 SHALL immediately force: state HOLD, sys_rst=1, ck_en=0, prescaler 0, stretch and watchdog counters 0, rst_cause=00, wdog_expired=0.
REQ-027 Assertion of rst_n mid-STRETCH or mid-RUN SHALL abort the current operation with no residual state.

Configuration
REQ-028 With macro RST_CTRL_WDOG_EN defined, the watchdog (REQ-020..022) SHALL be compiled in.
REQ-029 Without RST_CTRL_WDOG_EN, no watchdog counter exists, kick is ignored, wdog_expired is tied 0, and rst_cause never takes 10.

Verification (DIV=4, RST_CYCLES=5, WDOG_BITS=4, RST_CTRL_WDOG_EN defined)
REQ-030 Release rst_n with locked=1 -> ck_en pulses every 4 ck; sys_rst falls after the 5th ck_en; rst_cause=00.
REQ-031 reset_req pulse in RUN -> sys_rst=1 on the next edge, rst_cause=01; sys_rst falls after 5 further ck_en.
REQ-032 No kick in RUN -> wdog_expired pulse on the 16th ck_en (about 64 ck); rst_cause=10; re-enters RUN after 5 ck_en.
REQ-033 kick every 10 ck_en, plus one kick aligned exactly to the 16th tick -> wdog_expired stays 0 and sys_rst stays 0.
REQ-034 locked=0 and reset_req=1 in the same RUN cycle -> HOLD, rst_cause=11; locked=1 -> stretch of 5 ck_en, then RUN.
REQ-035 rst_n asserted mid-STRETCH -> all outputs at REQ-026 values in the same cycle; macro undefined -> no expiry after 100 ck_en.
